// File: rtl/subpixel_output_reader_pkg.sv
// -----------------------------------------------------------------------------
// subpixel_output_reader_pkg
//   Shared geometry, plane codes and FSM encoding for the subpixel output
//   reader. Everything that sizes a bus or a counter is derived from here.
// -----------------------------------------------------------------------------
package subpixel_output_reader_pkg;

    localparam int PIX_W      = 8;                     // bits per subpixel sample
    localparam int WORD_PIX   = 8;                     // samples per output word
    localparam int PLANE_PIX  = 320;                   // samples per plane
    localparam int WORDS      = PLANE_PIX / WORD_PIX;  // words per plane (40)
    localparam int WORD_W     = PIX_W * WORD_PIX;      // output word width (64)
    localparam int PLANE_W    = PIX_W * PLANE_PIX;     // plane width (2560)
    localparam int WORD_IDX_W = $clog2(WORDS);

    typedef logic [WORD_IDX_W-1:0] word_idx_t;

    localparam word_idx_t LAST_WORD = word_idx_t'(WORDS - 1);

    // Code 3 is never produced on the bus.
    typedef enum logic [1:0] {
        PLANE_A = 2'd0,
        PLANE_B = 2'd1,
        PLANE_C = 2'd2
    } plane_e;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Plane order A -> B -> C; C wraps to A only through the end-of-frame path.
    function automatic plane_e next_plane(input plane_e p);
        case (p)
            PLANE_A: next_plane = PLANE_B;
            PLANE_B: next_plane = PLANE_C;
            default: next_plane = PLANE_A;
        endcase
    endfunction

endpackage

// File: rtl/subpixel_output_reader_if.sv
// -----------------------------------------------------------------------------
// subpixel_output_reader_if
//   Valid/ready word stream from the reader to the downstream consumer.
//     out_data   word being offered
//     out_valid  out_data/out_plane/out_last are meaningful
//     out_ready  consumer accepts the word when out_valid && out_ready
//     out_plane  0=A, 1=B, 2=C
//     out_last   final word of the frame (plane C, last word)
//   master = reader side, slave = consumer side.
// -----------------------------------------------------------------------------
interface subpixel_output_reader_if;
    import subpixel_output_reader_pkg::*;

    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        out_plane;
    logic              out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_plane,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_plane,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/subpixel_output_reader_plane_word_mux.sv
// -----------------------------------------------------------------------------
// plane_word_mux
//   Pure combinational word selector: picks plane (A/B/C) and then the
//   64-bit word at index 'word' inside that plane.
//     shadow_a/b/c  plane snapshots, word w = shadow[w*WORD_W +: WORD_W]
//     plane         plane select
//     word          word index within the plane
//     word_data     selected word (zero for the unused plane code)
// -----------------------------------------------------------------------------
module plane_word_mux
    import subpixel_output_reader_pkg::*;
(
    input  logic [PLANE_W-1:0] shadow_a,
    input  logic [PLANE_W-1:0] shadow_b,
    input  logic [PLANE_W-1:0] shadow_c,
    input  plane_e             plane,
    input  word_idx_t          word,
    output logic [WORD_W-1:0]  word_data
);

    always_comb begin
        // NOTE: word_data gets a value before the case so no path leaves it unassigned and infers a latch.
        word_data = '0;
        case (plane)
            PLANE_A: word_data = shadow_a[word * WORD_W +: WORD_W];
            PLANE_B: word_data = shadow_b[word * WORD_W +: WORD_W];
            PLANE_C: word_data = shadow_c[word * WORD_W +: WORD_W];
            default: word_data = '0;
        endcase
    end

endmodule

// File: rtl/subpixel_output_reader.sv
// -----------------------------------------------------------------------------
// subpixel_output_reader
//   Drain end of the subpixel interpolation buffers. A frame_done pulse
//   snapshots planes A, B and C into shadow registers; the snapshot is then
//   streamed as 64-bit words, all of A, then B, then C, over valid/ready.
//   Ports:
//     clk          rising-edge clock
//     rst          asynchronous reset, active-low
//     frame_done   1-cycle pulse, in_A/in_B/in_C complete this cycle
//     in_A/B/C     plane buffers from the filler
//     out_if       word stream (master side)
//     busy         snapshot held, frame not fully drained
//     overrun      sticky, a frame_done was dropped while busy
//     overrun_clr  synchronous clear of overrun (a same-cycle set wins)
// -----------------------------------------------------------------------------
module subpixel_output_reader
    import subpixel_output_reader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_done,
    input  logic [PLANE_W-1:0]   in_A,
    input  logic [PLANE_W-1:0]   in_B,
    input  logic [PLANE_W-1:0]   in_C,
    subpixel_output_reader_if.master out_if,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    state_e             state_q, state_d;
    plane_e             plane_q, plane_d;
    word_idx_t          word_q, word_d;
    logic [PLANE_W-1:0] shadow_a_q, shadow_a_d;
    logic [PLANE_W-1:0] shadow_b_q, shadow_b_d;
    logic [PLANE_W-1:0] shadow_c_q, shadow_c_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               overrun_q, overrun_d;

    logic handshake;
    logic final_word;
    logic final_hs;
    logic accept;

    assign handshake  = (state_q == SEND) && out_if.out_ready;
    assign final_word = (plane_q == PLANE_C) && (word_q == LAST_WORD);
    assign final_hs   = handshake && final_word;
    // A new frame is taken when idle, or exactly as the last word leaves so
    // the stream continues without a bubble.
    assign accept     = frame_done && ((state_q == IDLE) || final_hs);

    // -------------------------------------------------------------------------
    // FSM next state and word/plane counters
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        word_d  = word_q;

        case (state_q)
            IDLE: begin
                // Wait for frame_done; handled by the accept override below.
            end
            SEND: begin
                if (handshake) begin
                    if (word_q != LAST_WORD) begin
                        word_d = word_q + 1'b1;
                    end else begin
                        word_d  = '0;
                        plane_d = next_plane(plane_q);
                    end
                    if (final_word) begin
                        state_d = IDLE;
                        plane_d = PLANE_A;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d = SEND;
            plane_d = PLANE_A;
            word_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot capture and overrun flag
    // -------------------------------------------------------------------------
    always_comb begin
        shadow_a_d = accept ? in_A : shadow_a_q;
        shadow_b_d = accept ? in_B : shadow_b_q;
        shadow_c_d = accept ? in_C : shadow_c_q;

        overrun_d = overrun_q;
        if (frame_done && !accept) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // out_data is registered, so the mux looks at the values the shadows and
    // counters will hold after this edge; the word is then ready the cycle
    // valid rises, with no combinational path from out_ready.
    plane_word_mux u_mux (
        .shadow_a  (shadow_a_d),
        .shadow_b  (shadow_b_d),
        .shadow_c  (shadow_c_d),
        .plane     (plane_d),
        .word      (word_d),
        .word_data (out_data_d)
    );

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            plane_q    <= PLANE_A;
            word_q     <= '0;
            out_data_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q    <= state_d;
            plane_q    <= plane_d;
            word_q     <= word_d;
            out_data_q <= out_data_d;
            overrun_q  <= overrun_d;
        end
    end

    // NOTE: the shadows are data-only storage whose contents are meaningless until a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        shadow_a_q <= shadow_a_d;
        shadow_b_q <= shadow_b_d;
        shadow_c_q <= shadow_c_d;
    end

    // -------------------------------------------------------------------------
    // Outputs, all decoded from registers
    // -------------------------------------------------------------------------
    assign out_if.out_valid = (state_q == SEND);
    assign out_if.out_data  = out_data_q;
    assign out_if.out_plane = plane_q;
    assign out_if.out_last  = (state_q == SEND) && final_word;
    assign busy             = (state_q == SEND);
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_subpixel_output_reader.sv
// -----------------------------------------------------------------------------
// tb_subpixel_output_reader
//   Directed sequence with randomized pixel data and ready patterns. The
//   reference model keeps a queue of the words a captured frame must produce;
//   a frame is accepted when the queue is empty or its last entry is leaving.
// -----------------------------------------------------------------------------
module tb_subpixel_output_reader;
    import subpixel_output_reader_pkg::*;

    typedef struct {
        logic [WORD_W-1:0] data;
        logic [1:0]        plane;
        logic              last;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               frame_done;
    logic               overrun_clr;
    logic               busy;
    logic               overrun;
    logic [PLANE_W-1:0] in_a;
    logic [PLANE_W-1:0] in_b;
    logic [PLANE_W-1:0] in_c;

    subpixel_output_reader_if bus ();

    subpixel_output_reader dut (
        .clk         (clk),
        .rst         (rst),
        .frame_done  (frame_done),
        .in_A        (in_a),
        .in_B        (in_b),
        .in_C        (in_c),
        .out_if      (bus),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               vectors     = 0;
    int               miscompares = 0;
    logic [PIX_W-1:0] pix [3][PLANE_PIX];
    exp_t             pending [$];
    logic             m_overrun;
    bit               scramble;
    bit               rand_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < PLANE_PIX; k++) begin
            pix[0][k] = PIX_W'(k);
            pix[1][k] = PIX_W'(k + 64);
            pix[2][k] = PIX_W'(k + 128);
        end
    endtask

    task automatic fill_random();
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < PLANE_PIX; k++)
                pix[p][k] = PIX_W'($urandom);
    endtask

    task automatic drive_planes();
        for (int k = 0; k < PLANE_PIX; k++) begin
            in_a[k*PIX_W +: PIX_W] = pix[0][k];
            in_b[k*PIX_W +: PIX_W] = pix[1][k];
            in_c[k*PIX_W +: PIX_W] = pix[2][k];
        end
    endtask

    // Word w of plane p: sample 8w in the low byte up to sample 8w+7 on top.
    function automatic logic [WORD_W-1:0] pack_word(input int p, input int w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int j = WORD_PIX - 1; j >= 0; j--)
            r = {r[WORD_W-PIX_W-1:0], pix[p][w*WORD_PIX + j]};
        return r;
    endfunction

    task automatic capture();
        exp_t e;
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < WORDS; w++) begin
                e.data  = pack_word(p, w);
                e.plane = 2'(p);
                e.last  = (p == 2) && (w == WORDS - 1);
                pending.push_back(e);
            end
        end
    endtask

    // Compare this cycle's outputs with the model, then advance the model
    // by what the coming clock edge will do.
    task automatic check_cycle();
        bit exp_busy;
        bit hs;
        bit acc;
        exp_busy = (pending.size() != 0);
        check("out_valid", 64'(bus.out_valid), 64'(exp_busy));
        check("busy", 64'(busy), 64'(exp_busy));
        check("overrun", 64'(overrun), 64'(m_overrun));
        if (exp_busy) begin
            check("out_data", bus.out_data, pending[0].data);
            check("out_plane", 64'(bus.out_plane), 64'(pending[0].plane));
            check("out_last", 64'(bus.out_last), 64'(pending[0].last));
        end
        hs  = exp_busy && bus.out_ready;
        acc = frame_done && (!exp_busy || (hs && pending.size() == 1));
        if (hs) void'(pending.pop_front());
        if (acc) capture();
        if (frame_done && !acc) m_overrun = 1'b1;
        else if (overrun_clr)   m_overrun = 1'b0;
    endtask

    task automatic cycle();
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        if (scramble) begin
            fill_random();
            drive_planes();
        end
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        cycle();
        frame_done = 1'b0;
    endtask

    task automatic run_until(input int remaining, input int budget);
        int n = 0;
        while (pending.size() > remaining && n < budget) begin
            cycle();
            n++;
        end
        check("run_budget", 64'(pending.size() > remaining), 64'd0);
    endtask

    task automatic drain(input int budget);
        run_until(0, budget);
    endtask

    initial begin
        int n;
        rst          = 1'b0;
        frame_done   = 1'b0;
        overrun_clr  = 1'b0;
        bus.out_ready = 1'b0;
        m_overrun    = 1'b0;
        scramble     = 1'b0;
        rand_ready   = 1'b0;
        in_a = '0;
        in_b = '0;
        in_c = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_plane", 64'(bus.out_plane), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_data", bus.out_data, 64'd0);
        rst = 1'b1;
        repeat (2) cycle();

        // Ramp with out_ready held high: 120 words on consecutive cycles
        fill_ramp();
        drive_planes();
        bus.out_ready = 1'b1;
        pulse_frame();
        check("ramp_word0", bus.out_data, 64'h0706050403020100);
        n = 0;
        while (pending.size() != 0 && n < 200) begin
            if (n == 39)  check("ramp_a_word39", bus.out_data, 64'h3F3E3D3C3B3A3938);
            if (n == 119) check("ramp_last", 64'(bus.out_last), 64'd1);
            cycle();
            n++;
        end
        check("ramp_cycles", 64'(n), 64'd120);
        repeat (2) cycle();

        // Backpressure on the ramp
        rand_ready = 1'b1;
        pulse_frame();
        drain(2000);
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        cycle();

        // Overrun: dropped frame_done at handshake 50, clear in the same cycle
        fill_random();
        drive_planes();
        pulse_frame();
        run_until(3 * WORDS - 50, 200);
        fill_random();
        drive_planes();
        frame_done  = 1'b1;
        overrun_clr = 1'b1;
        cycle();
        frame_done  = 1'b0;
        overrun_clr = 1'b0;
        check("overrun_set_wins", 64'(overrun), 64'd1);
        drain(200);
        overrun_clr = 1'b1;
        cycle();
        overrun_clr = 1'b0;
        check("overrun_clr", 64'(overrun), 64'd0);

        // Back-to-back: frame_done on the final handshake
        fill_random();
        drive_planes();
        pulse_frame();
        run_until(1, 200);
        fill_random();
        drive_planes();
        pulse_frame();
        check("b2b_valid", 64'(bus.out_valid), 64'd1);
        check("b2b_plane", 64'(bus.out_plane), 64'd0);
        check("b2b_word0", bus.out_data, pack_word(0, 0));
        check("b2b_overrun", 64'(overrun), 64'd0);
        drain(200);
        cycle();

        // Snapshot isolation: buffers change every cycle after capture
        fill_random();
        drive_planes();
        pulse_frame();
        scramble   = 1'b1;
        rand_ready = 1'b1;
        drain(2000);
        scramble   = 1'b0;
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        cycle();

        // Mid-frame asynchronous reset at plane 1, word 17, with overrun set
        fill_random();
        drive_planes();
        pulse_frame();
        run_until(100, 200);
        pulse_frame();
        run_until(3 * WORDS - 57, 200);
        check("pre_rst_plane", 64'(bus.out_plane), 64'd1);
        check("pre_rst_overrun", 64'(overrun), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_overrun", 64'(overrun), 64'd0);
        check("async_rst_last", 64'(bus.out_last), 64'd0);
        check("async_rst_data", bus.out_data, 64'd0);
        pending.delete();
        m_overrun = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) cycle();

        // Recovery frame after reset
        fill_ramp();
        drive_planes();
        pulse_frame();
        check("recover_word0", bus.out_data, 64'h0706050403020100);
        drain(200);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
